keypad_encoder: RTL and testbench
=================================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable samples required to accept a press or a release (range 1..255).
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 clrn  input  1  reset; asynchronous and active-low.
REQ-004 keys  input  10  raw keypad lines, active-high; bit i = digit key i (0..9).
REQ-005 en  input  1  entry enable; high = digits may be accepted (oven idle, not cooking).
REQ-006 entry_clr  input  1  synchronous clear of entered-digit count (cancel key).
REQ-007 data  output  4  BCD digit for the timer's shift-in port.
REQ-008 loadn  output  1  active-low load strobe to the timer; low for exactly one cycle per accepted digit.
REQ-009 digit_count  output  2  number of digits accepted since reset/clear, saturating at 3.
REQ-010 full  output  1  high when digit_count == 3.

Function
REQ-011 keys SHALL pass through one register stage (keys_q) before any decision; all rules below refer to keys_q.
REQ-012 A sample is "single" when exactly one bit of keys_q is set, "none" when all are 0, and "multi" otherwise.
REQ-013 FSM states SHALL be IDLE, DEBOUNCE, LOAD, RELEASE.
REQ-014 IDLE: on a single sample with en=1, capture the key index, clear the debounce counter, go to DEBOUNCE; otherwise stay.
REQ-015 DEBOUNCE: each cycle the sample is single and equals the captured key, increment the counter; when it reaches DEBOUNCE_CYCLES go to LOAD.
REQ-016 DEBOUNCE: on a none sample, a different key, or a multi sample, go to IDLE with no strobe.
REQ-017 DEBOUNCE: if en drops, go to IDLE with no strobe.
REQ-018 LOAD: lasts exactly one cycle, then go to RELEASE.
REQ-019 LOAD: loadn = 0 and data = captured key index (4-bit BCD, 0..9).
REQ-020 LOAD: digit_count increments by 1, or is left unchanged when already 3.
REQ-021 If full = 1 when DEBOUNCE completes, the FSM SHALL skip LOAD and go straight to RELEASE; loadn stays 1 and data is unchanged.
REQ-022 RELEASE: count consecutive none samples; after DEBOUNCE_CYCLES of them go to IDLE; any non-none sample restarts the count.
REQ-023 Holding a key SHALL produce exactly one strobe; no auto-repeat.
REQ-024 data SHALL be registered, updated only on entry to LOAD, and held stable until the next LOAD, so it is valid throughout the loadn-low cycle.
REQ-025 loadn SHALL be a registered output, glitch-free, and 1 in every state except LOAD.
REQ-026 Latency: with a key stable from rising edge k, loadn SHALL be low in the cycle following edge k+1+DEBOUNCE_CYCLES.
REQ-027 entry_clr = 1 SHALL set digit_count to 0 on the next edge and SHALL NOT change FSM state or data.
REQ-028 If entry_clr = 1 coincides with LOAD, the clear wins: digit_count becomes 0 and the strobe is still issued.
REQ-029 full SHALL be combinational from digit_count.

Reset
REQ-030 clrn = 0 SHALL immediately, regardless of clock, force state = IDLE, keys_q = 0, counters = 0, data = 4'd0, loadn = 1, digit_count = 0, full = 0.
REQ-031 Reset asserted mid-DEBOUNCE or mid-LOAD SHALL abort it with no further strobe; after release the block behaves as from power-up.

Verification (DEBOUNCE_CYCLES = 4)
REQ-032 Case 1: key 7 held for 20 cycles with en = 1 -> exactly one loadn pulse, data = 7, pulse in the cycle after edge k+5, digit_count = 1.
REQ-033 Case 2: key 3 bounces 1,0,1,1,0 and then holds stable for 6 cycles -> exactly one strobe, data = 3; no strobe during the bounce.
REQ-034 Case 3: keys 1, 2, 5, 9 entered with releases in between -> strobes with data 1, 2, 5; key 9 gives no strobe; full = 1; digit_count = 3.
REQ-035 Case 4: keys = 10'b0000010010 (multi) held -> no strobe; with en = 0 and key 4 held -> no strobe.
REQ-036 Case 5: clrn pulsed low between edges during DEBOUNCE of key 6 -> loadn = 1 and data = 0 immediately; no strobe until a fresh press.
REQ-037 Case 6: entry_clr asserted in the same cycle as LOAD of key 8 -> strobe with data = 8, digit_count = 0 afterwards.

Source files
------------

// File: rtl/keypad_encoder.sv
// Debounced 10-key digit entry for the oven timer: one load strobe per accepted
// key press, with the entered-digit count saturating at three.
module keypad_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [9:0] keys,
  input  logic       en,
  input  logic       entry_clr,
  output logic [3:0] data,
  output logic       loadn,
  output logic [1:0] digit_count,
  output logic       full
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    LOAD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  state_t     state_q;
  logic [9:0] keys_q;
  logic [3:0] key_q;
  logic [7:0] cnt_q;
  logic [3:0] data_q;
  logic       loadn_q;
  logic [1:0] digit_count_q;
  logic [1:0] digit_count_d;

  logic [3:0] ones_s;
  logic [3:0] sample_idx_s;
  logic       sample_single_s;
  logic       sample_none_s;
  logic [7:0] cnt_inc_s;
  logic       cnt_done_s;
  logic       full_s;

  function automatic logic [3:0] count_ones(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Only meaningful for single samples; picks the highest set line otherwise.
  function automatic logic [3:0] key_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign ones_s          = count_ones(keys_q);
  assign sample_idx_s    = key_index(keys_q);
  assign sample_single_s = (ones_s == 4'd1);
  assign sample_none_s   = (ones_s == 4'd0);
  assign cnt_inc_s       = cnt_q + 8'd1;
  assign cnt_done_s      = (cnt_inc_s == DB_LIMIT);
  assign full_s          = (digit_count_q == 2'd3);

  // Input sampling stage: every decision below looks at keys_q only.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      keys_q <= 10'd0;
    end else begin
      keys_q <= keys;
    end
  end

  // Digit counter next value: cancel beats the increment made during LOAD.
  always_comb begin
    digit_count_d = digit_count_q;
    if (entry_clr) begin
      digit_count_d = 2'd0;
    end else if ((state_q == LOAD) && (digit_count_q != 2'd3)) begin
      digit_count_d = digit_count_q + 2'd1;
    end else begin
      digit_count_d = digit_count_q;
    end
  end

  // Digit counter register.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      digit_count_q <= 2'd0;
    end else begin
      digit_count_q <= digit_count_d;
    end
  end

  // Press/debounce/load/release sequencer with registered strobe and digit.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      key_q   <= 4'd0;
      cnt_q   <= 8'd0;
      data_q  <= 4'd0;
      loadn_q <= 1'b1;
    end else begin
      loadn_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (en && sample_single_s) begin
            key_q   <= sample_idx_s;
            cnt_q   <= 8'd0;
            state_q <= DEBOUNCE;
          end else begin
            state_q <= IDLE;
          end
        end
        DEBOUNCE: begin
          if (!en || !sample_single_s || (sample_idx_s != key_q)) begin
            state_q <= IDLE;
          end else if (cnt_done_s) begin
            cnt_q <= 8'd0;
            // A full entry swallows the press but still waits for its release.
            if (full_s) begin
              state_q <= RELEASE;
            end else begin
              state_q <= LOAD;
              loadn_q <= 1'b0;
              data_q  <= key_q;
            end
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        LOAD: begin
          cnt_q   <= 8'd0;
          state_q <= RELEASE;
        end
        RELEASE: begin
          if (!sample_none_s) begin
            cnt_q <= 8'd0;
          end else if (cnt_done_s) begin
            cnt_q   <= 8'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign loadn       = loadn_q;
  assign digit_count = digit_count_q;
  assign full        = full_s;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed spec cases plus randomized key traffic
// checked cycle by cycle against a behavioural model.
module tb_keypad_encoder;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic [9:0] keys = 10'd0;
  logic       en = 1'b1;
  logic       entry_clr = 1'b0;
  logic [3:0] data;
  logic       loadn;
  logic [1:0] digit_count;
  logic       full;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-scenario strobe observation.
  int         cyc;
  int         strobes;
  int         first_at;
  logic [3:0] strobe_q[$];

  // Behavioural model: phase 0 = waiting for a press, 1 = qualifying it,
  // 2 = waiting for the keypad to go quiet.
  int         m_phase;
  int         m_cand;
  int         m_n;
  logic [9:0] m_kq;
  logic       m_loadn;
  logic [3:0] m_data;
  int         m_dc;

  keypad_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .clrn(clrn), .keys(keys), .en(en), .entry_clr(entry_clr),
    .data(data), .loadn(loadn), .digit_count(digit_count), .full(full)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_phase = 0; m_cand = 0; m_n = 0; m_kq = 10'd0;
    m_loadn = 1'b1; m_data = 4'd0; m_dc = 0;
  endtask

  task automatic model_edge(input logic [9:0] kq, input logic e, input logic c);
    int ones, idx, dc_next;
    bit in_strobe;
    ones = 0; idx = -1;
    for (int i = 0; i < 10; i++) if (kq[i]) begin ones++; idx = i; end
    in_strobe = (m_loadn == 1'b0);
    dc_next = c ? 0 : ((in_strobe && m_dc < 3) ? m_dc + 1 : m_dc);
    m_loadn = 1'b1;
    if (in_strobe) begin
      m_phase = 2; m_n = 0;
    end else if (m_phase == 0) begin
      if (e && ones == 1) begin m_cand = idx; m_n = 0; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (!e || ones != 1 || idx != m_cand) m_phase = 0;
      else if (m_n + 1 == DB) begin
        m_n = 0; m_phase = 2;
        if (m_dc != 3) begin m_loadn = 1'b0; m_data = 4'(m_cand); end
      end else m_n++;
    end else begin
      if (ones != 0) m_n = 0;
      else if (m_n + 1 == DB) begin m_n = 0; m_phase = 0; end
      else m_n++;
    end
    m_dc = dc_next;
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, observe.
  task automatic step(input logic [9:0] k, input logic e, input logic c);
    keys = k; en = e; entry_clr = c;
    @(posedge clock);
    if (clrn) begin
      model_edge(m_kq, e, c);
      m_kq = k;
    end else model_reset();
    #1;
    cyc++;
    if (loadn === 1'b0) begin
      strobes++;
      if (first_at == 0) first_at = cyc;
      strobe_q.push_back(data);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; strobes = 0; first_at = 0; strobe_q.delete();
  endtask

  task automatic hold(input logic [9:0] k, input logic e, input int n);
    for (int i = 0; i < n; i++) step(k, e, 1'b0);
  endtask

  task automatic test_reset();
    clrn = 1'b0; keys = 10'd0; en = 1'b1; entry_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (loadn !== 1'b1) begin n_bad++; $display("FAIL reset_loadn: got %b expected 1", loadn); end
    n_cmp++; if (data !== 4'd0) begin n_bad++; $display("FAIL reset_data: got %0d expected 0", data); end
    n_cmp++; if (digit_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", digit_count); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", full); end
    clrn = 1'b1;
    hold(10'd0, 1'b1, 2);
  endtask

  task automatic test_single_press();
    clear_obs();
    hold(10'd1 << 7, 1'b1, 20);
    hold(10'd0, 1'b1, 8);
    n_cmp++; if (strobes != 1) begin n_bad++; $display("FAIL hold7_strobes: got %0d expected 1", strobes); end
    n_cmp++; if (first_at != DB + 2) begin n_bad++; $display("FAIL hold7_latency: got cycle %0d expected %0d", first_at, DB + 2); end
    n_cmp++; if (strobe_q.size() < 1 || strobe_q[0] !== 4'd7) begin n_bad++; $display("FAIL hold7_data: got %0d expected 7", data); end
    n_cmp++; if (digit_count !== 2'd1) begin n_bad++; $display("FAIL hold7_count: got %0d expected 1", digit_count); end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b01101;  // bit 0 first: 1,0,1,1,0
    clear_obs();
    for (int i = 0; i < 5; i++) step(pat[i] ? (10'd1 << 3) : 10'd0, 1'b1, 1'b0);
    hold(10'd1 << 3, 1'b1, 6);
    hold(10'd0, 1'b1, 10);
    n_cmp++; if (strobes != 1) begin n_bad++; $display("FAIL bounce_strobes: got %0d expected 1", strobes); end
    n_cmp++; if (first_at != 11) begin n_bad++; $display("FAIL bounce_latency: got cycle %0d expected 11", first_at); end
    n_cmp++; if (strobe_q.size() < 1 || strobe_q[0] !== 4'd3) begin n_bad++; $display("FAIL bounce_data: got %0d expected 3", data); end
  endtask

  task automatic test_entry_full();
    int seq[4];
    seq = '{1, 2, 5, 9};
    step(10'd0, 1'b1, 1'b1);
    n_cmp++; if (digit_count !== 2'd0) begin n_bad++; $display("FAIL clr_count: got %0d expected 0", digit_count); end
    n_cmp++; if (data !== 4'd3) begin n_bad++; $display("FAIL clr_keeps_data: got %0d expected 3", data); end
    clear_obs();
    foreach (seq[i]) begin
      hold(10'd1 << seq[i], 1'b1, 8);
      hold(10'd0, 1'b1, 8);
    end
    n_cmp++; if (strobes != 3) begin n_bad++; $display("FAIL full_strobes: got %0d expected 3", strobes); end
    n_cmp++;
    if (strobe_q.size() != 3 || strobe_q[0] !== 4'd1 || strobe_q[1] !== 4'd2 || strobe_q[2] !== 4'd5) begin
      n_bad++; $display("FAIL full_digits: got %0d strobes, last data %0d expected 1,2,5", strobe_q.size(), data);
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b expected 1", full); end
    n_cmp++; if (digit_count !== 2'd3) begin n_bad++; $display("FAIL full_count: got %0d expected 3", digit_count); end
    n_cmp++; if (data !== 4'd5) begin n_bad++; $display("FAIL full_data_held: got %0d expected 5", data); end
  endtask

  task automatic test_rejects();
    clear_obs();
    hold(10'b0000010010, 1'b1, 12);
    hold(10'd0, 1'b1, 6);
    hold(10'd1 << 4, 1'b0, 12);
    hold(10'd0, 1'b1, 6);
    n_cmp++; if (strobes != 0) begin n_bad++; $display("FAIL multi_or_disabled_strobes: got %0d expected 0", strobes); end
  endtask

  task automatic test_reset_mid_debounce();
    clear_obs();
    hold(10'd1 << 6, 1'b1, 3);
    #2 clrn = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (loadn !== 1'b1) begin n_bad++; $display("FAIL midrst_loadn: got %b expected 1", loadn); end
    n_cmp++; if (data !== 4'd0) begin n_bad++; $display("FAIL midrst_data: got %0d expected 0", data); end
    n_cmp++; if (digit_count !== 2'd0) begin n_bad++; $display("FAIL midrst_count: got %0d expected 0", digit_count); end
    clrn = 1'b1;
    keys = 10'd0;
    hold(10'd0, 1'b1, 10);
    n_cmp++; if (strobes != 0) begin n_bad++; $display("FAIL midrst_no_strobe: got %0d expected 0", strobes); end
    clear_obs();
    hold(10'd1 << 1, 1'b1, 8);
    hold(10'd0, 1'b1, 8);
    n_cmp++; if (strobes != 1 || strobe_q[0] !== 4'd1) begin n_bad++; $display("FAIL midrst_fresh: got %0d strobes data %0d expected 1 strobe data 1", strobes, data); end
  endtask

  task automatic test_clear_during_load();
    clear_obs();
    hold(10'd1 << 8, 1'b1, DB + 2);
    step(10'd1 << 8, 1'b1, 1'b1);
    hold(10'd1 << 8, 1'b1, 3);
    hold(10'd0, 1'b1, 8);
    n_cmp++; if (strobes != 1 || first_at != DB + 2) begin n_bad++; $display("FAIL clrload_strobe: got %0d strobes at %0d expected 1 at %0d", strobes, first_at, DB + 2); end
    n_cmp++; if (strobe_q.size() < 1 || strobe_q[0] !== 4'd8) begin n_bad++; $display("FAIL clrload_data: got %0d expected 8", data); end
    n_cmp++; if (digit_count !== 2'd0) begin n_bad++; $display("FAIL clrload_count: got %0d expected 0", digit_count); end
  endtask

  task automatic test_random();
    logic [9:0] k;
    logic       e;
    int         len, sel, bad_here;
    bad_here = 0;
    test_reset();
    for (int seg = 0; seg < 120; seg++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) k = 10'd1 << $urandom_range(0, 9);
      else if (sel < 8) k = 10'd0;
      else k = 10'($urandom) | 10'b0000000011;
      e = ($urandom_range(0, 9) != 0);
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        step(k, e, ($urandom_range(0, 29) == 0));
        n_cmp++;
        if (loadn !== m_loadn || data !== m_data || digit_count !== 2'(m_dc) || full !== (m_dc == 3)) begin
          n_bad++;
          if (bad_here < 5)
            $display("FAIL random_cycle: got loadn=%b data=%0d count=%0d full=%b expected loadn=%b data=%0d count=%0d full=%b",
                     loadn, data, digit_count, full, m_loadn, m_data, m_dc, (m_dc == 3));
          bad_here++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_entry_full();
    test_rejects();
    test_reset_mid_debounce();
    test_clear_during_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
